// File: rtl/serial_add_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : half_adder / serial_add_ctrl                                 |
// | Description : Bit-serial WIDTH-bit add/subtract sequencer. A single 1-bit  |
// |               full-adder cell (two half adders plus an OR) processes one   |
// |               operand bit per clock, LSB first, and reports the result     |
// |               with a one-cycle done pulse.                                 |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+

// Basic half-adder cell used twice to build the serial full adder.
module half_adder (
    input  logic i_a,
    input  logic i_b,
    output logic o_sum,
    output logic o_carry
);

    assign o_sum   = i_a ^ i_b;
    assign o_carry = i_a & i_b;

endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Bit counter is at least one bit wide so WIDTH=1 still has a legal vector.
    localparam int                  c_CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [c_CNT_W-1:0]  c_LAST  = c_CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               r_state;
    logic [WIDTH-1:0]     r_opa;
    logic [WIDTH-1:0]     r_opb;
    logic                 r_carry;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]     r_sum;
    logic                 r_cout;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_ha1_sum;
    logic                 w_ha1_carry;
    logic                 w_ha2_sum;
    logic                 w_ha2_carry;
    logic                 w_cell_carry;
    logic [WIDTH-1:0]     w_sum_next;

    // Serial full adder: first half adder combines the operand bits, the
    // second folds in the running carry; either stage may generate the carry.
    half_adder u_ha1 (
        .i_a     (r_opa[0]),
        .i_b     (r_opb[0]),
        .o_sum   (w_ha1_sum),
        .o_carry (w_ha1_carry)
    );

    half_adder u_ha2 (
        .i_a     (w_ha1_sum),
        .i_b     (r_carry),
        .o_sum   (w_ha2_sum),
        .o_carry (w_ha2_carry)
    );

    assign w_cell_carry = w_ha1_carry | w_ha2_carry;

    // Result is assembled by shifting each new bit in at the MSB so that the
    // first (LSB) bit ends up at position 0 after WIDTH shifts.
    generate
        if (WIDTH == 1) begin : g_sum_w1
            assign w_sum_next = w_ha2_sum;
        end else begin : g_sum_wn
            assign w_sum_next = {w_ha2_sum, r_sum[WIDTH-1:1]};
        end
    endgenerate

    // Sequencer: latch operands on start, shift through the cell for WIDTH
    // cycles, then pulse done for one cycle before returning to idle.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_opa   <= '0;
            r_opb   <= '0;
            r_carry <= 1'b0;
            r_cnt   <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (start) begin
                        // Subtraction is a + ~b + 1: invert B and seed carry.
                        r_opa   <= a;
                        r_opb   <= sub ? ~b : b;
                        r_carry <= sub;
                        r_cnt   <= '0;
                        r_sum   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_RUN;
                    end
                end

                S_RUN: begin
                    r_sum   <= w_sum_next;
                    r_opa   <= r_opa >> 1;
                    r_opb   <= r_opb >> 1;
                    r_carry <= w_cell_carry;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == c_LAST) begin
                        r_cout  <= w_cell_carry;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    // start is deliberately not looked at here.
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end

                default: begin
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = r_busy;
    assign done = r_done;
    assign sum  = r_sum;
    assign cout = r_cout;

endmodule
`default_nettype wire
